// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared constants and the state type for the write-back
// round-robin arbiter and its pick helper.

package wb_arb_pkg;

  // Eight write-back sources, addressed by a 3-bit index that feeds the
  // downstream 3-to-8 write-enable decoder.
  localparam int REQ_N = 8;
  localparam int IDX_W = 3;

  // IDLE: no grant outstanding. GRANT: a grant is presented and held until
  // the register-file write port accepts it.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/wb_rr_pick.sv
// wb_rr_pick: combinational round-robin search. It finds the first set bit
// of i_req at or above i_start, wrapping 7 -> 0. The search rotates the
// request vector so that i_start lands on bit 0, priority-encodes the
// lowest set bit, and adds i_start back to undo the rotation.

module wb_rr_pick
  import wb_arb_pkg::*;
(
  input  logic [REQ_N-1:0] i_req,
  input  logic [IDX_W-1:0] i_start,
  output logic             o_found,
  output logic [IDX_W-1:0] o_idx
);

  logic [2*REQ_N-1:0] w_dbl;
  logic [REQ_N-1:0]   w_rot;
  logic [IDX_W-1:0]   w_off;

  // Rotate right by i_start so the search origin becomes bit 0.
  always_comb begin
    w_dbl = {i_req, i_req} >> i_start;
    w_rot = w_dbl[REQ_N-1:0];
  end

  // Priority-encode the lowest set bit of the rotated vector.
  always_comb begin
    w_off = '0;
    for (int k = REQ_N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = IDX_W'(k);
      end
    end
  end

  // Undo the rotation; the 3-bit add wraps naturally modulo 8.
  always_comb begin
    o_found = |i_req;
    o_idx   = i_start + w_off;
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin arbiter for eight write-back sources sharing
// one register-file write port. It registers the winning index together
// with that source's payload, so index and data reach the register file
// in the same cycle. A grant is held until the consumer accepts it; on
// acceptance, the next winner (if any) is loaded back-to-back.

module wb_rr_arbiter #(
  parameter int DATA_W = 32,
  parameter int REQ_N  = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [REQ_N-1:0]             i_req,
  input  logic [REQ_N*DATA_W-1:0]      i_data,
  output logic                         o_gnt_vld,
  output logic [wb_arb_pkg::IDX_W-1:0] o_gnt_idx,
  output logic [DATA_W-1:0]            o_data,
  input  logic                         i_gnt_rdy,
  output logic                         o_busy
);

  import wb_arb_pkg::*;

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_gnt_idx;
  logic [DATA_W-1:0] r_data;

  logic [REQ_N-1:0] w_pick_req;
  logic [IDX_W-1:0] w_pick_start;
  logic             w_found;
  logic [IDX_W-1:0] w_win;
  logic [DATA_W-1:0] w_win_data;
  logic             w_accept;
  logic             w_load;

  // Choose what the picker searches. In IDLE, search starts at the
  // priority pointer. While a grant is presented, the current holder is
  // masked out and the search starts just above it. This is exactly where
  // the pointer will move if the grant is accepted, so a back-to-back pick
  // already honours the updated pointer.
  always_comb begin
    w_accept = (r_state == GRANT) && i_gnt_rdy;
    if (r_state == GRANT) begin
      w_pick_req   = i_req & ~(REQ_N'(1) << r_gnt_idx);
      w_pick_start = r_gnt_idx + IDX_W'(1);
    end else begin
      w_pick_req   = i_req;
      w_pick_start = r_ptr;
    end
  end

  wb_rr_pick u_pick (
    .i_req   (w_pick_req),
    .i_start (w_pick_start),
    .o_found (w_found),
    .o_idx   (w_win)
  );

  // Select the winner's payload so it can be captured alongside its index.
  always_comb begin
    w_win_data = i_data[w_win*DATA_W +: DATA_W];
  end

  // State register; reset drops any outstanding grant immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: a grant is never revoked. It is only replaced by a
  // new winner, or retired to IDLE, on an edge where the consumer accepts.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = GRANT;
          w_load      = 1'b1;
        end
      end
      GRANT: begin
        if (i_gnt_rdy) begin
          if (w_found) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Grant index, payload and priority pointer. The payload is sampled only
  // at the arbitration edge, so later changes on i_data cannot disturb a
  // held grant.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr     <= '0;
      r_gnt_idx <= '0;
      r_data    <= '0;
    end else begin
      if (w_accept) begin
        r_ptr <= r_gnt_idx + IDX_W'(1);
      end
      if (w_load) begin
        r_gnt_idx <= w_win;
        r_data    <= w_win_data;
      end
    end
  end

  // Output decode. Valid and busy both mean "a grant is being presented".
  always_comb begin
    o_gnt_vld = (r_state == GRANT);
    o_busy    = (r_state == GRANT);
    o_gnt_idx = r_gnt_idx;
    o_data    = r_data;
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: directed and constrained-random checks for the
// write-back round-robin arbiter. All expectations are computed here.

module tb_wb_rr_arbiter;

  localparam int DATA_W = 32;
  localparam int REQ_N  = 8;

  logic                    clk;
  logic                    rstN;
  logic [REQ_N-1:0]        req;
  logic [REQ_N*DATA_W-1:0] data;
  logic                    gntVld;
  logic [2:0]              gntIdx;
  logic [DATA_W-1:0]       gntData;
  logic                    gntRdy;
  logic                    busy;

  int errCount;
  int checkCount;
  int xferCount;

  logic [REQ_N-1:0] pending;
  int               waitCnt [REQ_N];

  wb_rr_arbiter #(
    .DATA_W (DATA_W),
    .REQ_N  (REQ_N)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rstN),
    .i_req     (req),
    .i_data    (data),
    .o_gnt_vld (gntVld),
    .o_gnt_idx (gntIdx),
    .o_data    (gntData),
    .i_gnt_rdy (gntRdy),
    .o_busy    (busy)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends even if the design stalls the bench.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Count one comparison and report it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive request and ready, then advance to just after the next rising edge.
  task automatic applyStimulus(input logic [REQ_N-1:0] reqVal, input logic rdyVal);
    req    = reqVal;
    gntRdy = rdyVal;
    @(posedge clk);
    #1;
  endtask

  // Give every source a recognisable payload: base + source number.
  task automatic setData(input logic [31:0] base);
    for (int k = 0; k < REQ_N; k++) begin
      data[k*DATA_W +: DATA_W] = base + 32'(k);
    end
  endtask

  // One cycle of the random traffic model. Sources keep requesting until
  // acknowledged, then drop on the edge after their ack.
  task automatic stepRandom(input bit allowNew, input bit forceRdy);
    logic       curVld;
    logic [2:0] curIdx;
    logic [31:0] curData;
    logic       rdyNow;
    curVld  = gntVld;
    curIdx  = gntIdx;
    curData = gntData;
    if (allowNew) begin
      for (int k = 0; k < REQ_N; k++) begin
        if (!pending[k] && ($urandom_range(3) == 0)) begin
          pending[k] = 1'b1;
          waitCnt[k] = 0;
        end
      end
    end
    rdyNow = forceRdy ? 1'b1 : ($urandom_range(2) != 0);
    for (int k = 0; k < REQ_N; k++) begin
      data[k*DATA_W +: DATA_W] = $urandom;
    end
    applyStimulus(pending, rdyNow);
    if (curVld && !rdyNow) begin
      checkOutput("holdVld", gntVld, 1);
      checkOutput("holdIdx", gntIdx, curIdx);
      checkOutput("holdData", gntData, curData);
    end
    if (curVld && rdyNow) begin
      xferCount++;
      checkOutput("ackWasRequested", pending[curIdx], 1);
      pending[curIdx] = 1'b0;
      waitCnt[curIdx] = 0;
      for (int k = 0; k < REQ_N; k++) begin
        if (pending[k]) begin
          waitCnt[k]++;
          checkOutput("fairWaitOver7", waitCnt[k] > 7, 0);
        end
      end
    end
  endtask

  // Main stimulus sequence.
  initial begin
    errCount   = 0;
    checkCount = 0;
    xferCount  = 0;
    pending    = '0;
    for (int k = 0; k < REQ_N; k++) waitCnt[k] = 0;
    req    = '0;
    gntRdy = 1'b0;
    rstN   = 1'b0;
    setData(32'hA000_0000);

    // Reset state.
    #12;
    checkOutput("rstVld", gntVld, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstIdx", gntIdx, 0);
    checkOutput("rstData", gntData, 0);
    @(negedge clk);
    rstN = 1'b1;

    // No requests: nothing is granted.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(8'h00, 1'b0);
      checkOutput("idleVld", gntVld, 0);
    end
    checkOutput("idleIdx", gntIdx, 0);
    checkOutput("idleData", gntData, 0);

    // All sources requesting, ready tied high: strict rotation, no gaps.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(8'hFF, 1'b1);
      checkOutput("rotVld", gntVld, 1);
      checkOutput("rotIdx", gntIdx, 64'(i % 8));
      checkOutput("rotData", gntData, 64'(32'hA000_0000 + 32'(i % 8)));
    end
    applyStimulus(8'h00, 1'b1);
    checkOutput("rotEndVld", gntVld, 0);
    checkOutput("rotEndBusy", busy, 0);

    // Single request held without ready: index and payload stay frozen.
    data[5*DATA_W +: DATA_W] = 32'h5555_0001;
    applyStimulus(8'h20, 1'b0);
    checkOutput("holdFirstIdx", gntIdx, 5);
    checkOutput("holdFirstData", gntData, 32'h5555_0001);
    data[5*DATA_W +: DATA_W] = 32'h5555_0002;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'h20, 1'b0);
      checkOutput("holdStableVld", gntVld, 1);
      checkOutput("holdStableIdx", gntIdx, 5);
      checkOutput("holdStableData", gntData, 32'h5555_0001);
    end
    applyStimulus(8'h20, 1'b1);
    checkOutput("holdReleaseVld", gntVld, 0);

    // Pointer now 6: grant 6, then with 6 masked the search wraps to 0.
    setData(32'hA000_0000);
    applyStimulus(8'h40, 1'b0);
    checkOutput("wrapFirstIdx", gntIdx, 6);
    applyStimulus(8'h41, 1'b1);
    checkOutput("wrapVld", gntVld, 1);
    checkOutput("wrapIdx", gntIdx, 0);
    checkOutput("wrapData", gntData, 32'hA000_0000);
    applyStimulus(8'h00, 1'b1);
    checkOutput("wrapEndVld", gntVld, 0);

    // Pointer 1: grant 7, then an asynchronous reset between edges.
    applyStimulus(8'h80, 1'b0);
    checkOutput("preRstIdx", gntIdx, 7);
    checkOutput("preRstVld", gntVld, 1);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("asyncRstVld", gntVld, 0);
    checkOutput("asyncRstBusy", busy, 0);
    checkOutput("asyncRstIdx", gntIdx, 0);
    checkOutput("asyncRstData", gntData, 0);
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus(8'h80, 1'b0);
    checkOutput("postRstVld", gntVld, 1);
    checkOutput("postRstIdx", gntIdx, 7);
    checkOutput("postRstData", gntData, 32'hA000_0007);
    applyStimulus(8'h81, 1'b1);
    checkOutput("postRstNextIdx", gntIdx, 0);
    applyStimulus(8'h00, 1'b1);
    checkOutput("postRstEndVld", gntVld, 0);

    // Pointer 1 with sources 0 and 2: 2 first, then a wrap back to 0.
    applyStimulus(8'h05, 1'b0);
    checkOutput("ptrPickIdx", gntIdx, 2);
    applyStimulus(8'h05, 1'b1);
    checkOutput("ptrWrapIdx", gntIdx, 0);
    checkOutput("ptrWrapData", gntData, 32'hA000_0000);
    applyStimulus(8'h00, 1'b1);
    checkOutput("ptrEndVld", gntVld, 0);

    // Random traffic with random ready, then drain with ready high.
    for (int cyc = 0; cyc < 10000; cyc++) begin
      stepRandom(1'b1, 1'b0);
    end
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (pending != '0 || gntVld) begin
        stepRandom(1'b0, 1'b1);
      end
    end
    checkOutput("drainPending", pending, 0);
    checkOutput("randomActivity", xferCount > 1000, 1);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
